// File: rtl/commu_rx_inf.sv
// Serial link receiver: one start bit, 16 data bits MSB first, two stop bits.
// Recovers one word per frame, flags bad stop bits and keeps a saturating error count.
module commu_rx_inf #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        rx,
    input  logic [19:0] tbit_period,
    output logic [15:0] data_rx,
    output logic        done_rx,
    output logic        err_frame,
    output logic        busy_rx,
    output logic [7:0]  cnt_err,
    input  logic        clr_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_d;
    logic                   fall;
    logic [19:0]            per;
    logic [19:0]            half;
    logic [19:0]            cnt;
    logic [3:0]             bit_idx;
    logic [15:0]            shreg;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign fall    = ~rx_s & rx_d;
    assign half    = per >> 1;
    assign busy_rx = (state != S_IDLE);

    // Input synchronizer and edge-detect flop; idle-high so reset never fakes a start edge
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sync_q <= '1;
            rx_d   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_d   <= rx_s;
        end
    end

    // Frame state machine; bit samples are taken near the middle of each bit
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            data_rx   <= '0;
            done_rx   <= 1'b0;
            err_frame <= 1'b0;
            cnt_err   <= '0;
        end else begin
            done_rx   <= 1'b0;
            err_frame <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fall && (tbit_period >= 20'd4)) begin
                        per   <= tbit_period;
                        cnt   <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == half - 20'd1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            bit_idx <= 4'd15;
                            state   <= S_DATA;
                        end
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                S_DATA: begin
                    if (cnt == per - 20'd1) begin
                        cnt   <= '0;
                        shreg <= {shreg[14:0], rx_s};
                        if (bit_idx == 4'd0) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx - 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                S_STOP: begin
                    if (cnt == per - 20'd1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_rx <= shreg;
                            done_rx <= 1'b1;
                        end else begin
                            err_frame <= 1'b1;
                            if (cnt_err != 8'hFF) begin
                                cnt_err <= cnt_err + 8'd1;
                            end
                        end
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                S_WAIT: begin
                    // A held-low line (break) parks here instead of producing frames
                    if (rx_s) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
            if (clr_err) begin
                cnt_err <= '0;
            end
        end
    end

endmodule

// File: tb/tb_commu_rx_inf.sv
// Directed self-checking bench for commu_rx_inf: frames, glitches, framing errors,
// error counter saturation/clear, reset mid-frame.
module tb_commu_rx_inf;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        rx;
    logic [19:0] tbit_period;
    logic [15:0] data_rx;
    logic        done_rx;
    logic        err_frame;
    logic        busy_rx;
    logic [7:0]  cnt_err;
    logic        clr_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    bit busy_seen = 0;
    int d0, e0;

    commu_rx_inf #(.SYNC_STAGES(2)) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .rx          (rx),
        .tbit_period (tbit_period),
        .data_rx     (data_rx),
        .done_rx     (done_rx),
        .err_frame   (err_frame),
        .busy_rx     (busy_rx),
        .cnt_err     (cnt_err),
        .clr_err     (clr_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (done_rx) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (err_frame) err_cnt = err_cnt + 1;
        if (done_rx && err_frame) both_cnt = both_cnt + 1;
        if (busy_rx) busy_seen = 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int p);
        rx = b;
        repeat (p) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input logic stop1, input int p);
        tbit_period = 20'(p);
        start_cyc = cyc;
        drive_bit(1'b0, p);
        for (int i = 15; i >= 0; i--) drive_bit(w[i], p);
        drive_bit(stop1, p);
        drive_bit(1'b1, p);
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        clr_err = 1'b0;
        tbit_period = 20'd20;
        repeat (4) @(posedge clk_sys);
        #1;
        rst = 1'b0;
        idle(20);

        // Reset state
        check("rst_data", 32'(data_rx), 32'h0);
        check("rst_busy", 32'(busy_rx), 32'h0);
        check("rst_cnt_err", 32'(cnt_err), 32'h0);
        check("rst_no_pulse", 32'(done_cnt + err_cnt), 32'h0);

        // Single frame, with latency 3 + half + 17*per = 3 + 10 + 340
        send_frame(16'hA5C3, 1'b1, 20);
        idle(5);
        check("single_done", 32'(done_cnt), 32'd1);
        check("single_data", 32'(data_rx), 32'hA5C3);
        check("single_no_err", 32'(err_cnt), 32'd0);
        check("single_latency", 32'(done_cyc - start_cyc), 32'd353);

        // Back-to-back frames with only the two stop bits between them
        d0 = done_cnt;
        send_frame(16'h0001, 1'b1, 8);
        check("b2b_data0", 32'(data_rx), 32'h0001);
        send_frame(16'hFFFF, 1'b1, 8);
        check("b2b_data1", 32'(data_rx), 32'hFFFF);
        send_frame(16'h8000, 1'b1, 8);
        check("b2b_data2", 32'(data_rx), 32'h8000);
        check("b2b_count", 32'(done_cnt - d0), 32'd3);
        idle(5);

        // Glitch rejection
        d0 = done_cnt;
        e0 = err_cnt;
        busy_seen = 0;
        tbit_period = 20'd100;
        drive_bit(1'b0, 10);
        idle(200);
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_idle", 32'(busy_rx), 32'd0);
        check("glitch_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        check("glitch_cnt_err", 32'(cnt_err), 32'd0);

        // Framing error keeps previous data, then a good frame
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(16'h1234, 1'b0, 16);
        idle(5);
        check("ferr_pulse", 32'(err_cnt - e0), 32'd1);
        check("ferr_no_done", 32'(done_cnt - d0), 32'd0);
        check("ferr_cnt_err", 32'(cnt_err), 32'd1);
        check("ferr_data_kept", 32'(data_rx), 32'h8000);
        send_frame(16'h5678, 1'b1, 16);
        idle(5);
        check("ferr_next_done", 32'(done_cnt - d0), 32'd1);
        check("ferr_next_data", 32'(data_rx), 32'h5678);

        // Clear, then saturate the error counter
        clr_err = 1'b1;
        @(posedge clk_sys);
        #1;
        clr_err = 1'b0;
        check("clr_cnt_err", 32'(cnt_err), 32'd0);
        e0 = err_cnt;
        for (int i = 0; i < 255; i++) send_frame(16'h00FF, 1'b0, 4);
        idle(3);
        check("sat_255", 32'(cnt_err), 32'hFF);
        send_frame(16'h00FF, 1'b0, 4);
        send_frame(16'h00FF, 1'b0, 4);
        idle(3);
        check("sat_257", 32'(cnt_err), 32'hFF);
        check("sat_pulses", 32'(err_cnt - e0), 32'd257);

        // Clear in the very cycle the error increment lands (edge 3 + 2 + 68 = 73)
        e0 = err_cnt;
        fork
            send_frame(16'h0F0F, 1'b0, 4);
            begin
                repeat (72) begin
                    @(posedge clk_sys);
                end
                #1;
                clr_err = 1'b1;
                @(posedge clk_sys);
                #1;
                clr_err = 1'b0;
            end
        join
        idle(3);
        check("clr_vs_inc_pulse", 32'(err_cnt - e0), 32'd1);
        check("clr_vs_inc_cnt", 32'(cnt_err), 32'd0);

        // Bit period below 4 is refused
        d0 = done_cnt;
        busy_seen = 0;
        send_frame(16'hC3C3, 1'b1, 3);
        idle(5);
        check("short_per_busy", 32'(busy_seen), 32'd0);
        check("short_per_no_done", 32'(done_cnt - d0), 32'd0);

        // Reset mid-frame aborts silently, then a clean frame
        d0 = done_cnt;
        e0 = err_cnt;
        tbit_period = 20'd8;
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        rx = 1'b1;
        rst = 1'b1;
        @(posedge clk_sys);
        #1;
        rst = 1'b0;
        idle(10);
        check("mid_rst_busy", 32'(busy_rx), 32'd0);
        check("mid_rst_data", 32'(data_rx), 32'h0);
        check("mid_rst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        send_frame(16'hBEEF, 1'b1, 8);
        idle(200);
        check("mid_rst_clean_done", 32'(done_cnt - d0), 32'd1);
        check("mid_rst_clean_data", 32'(data_rx), 32'hBEEF);
        check("never_both_pulses", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
